// File: rtl/gpio_in_6502_pkg.sv
// Shared register indices for the 6502-bus GPIO input block.
package gpio_in_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_POL  = 2'd3;

endpackage

// File: rtl/gpio_in_6502_if.sv
// CPU-side register window of the GPIO input block: select, write strobe, address, data and IRQ.
interface gpio_in_6502_if;

  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output cs, we, addr, din, input dout, irq);
  modport slave  (input cs, we, addr, din, output dout, irq);

endinterface

// File: rtl/gpio_in_6502_debounce.sv
// One input bit: 2-FF synchroniser, optional debounce counter (GPIO_IN_DEBOUNCE_EN) and stable flop.
// update is high in the cycle where stable takes the synchronised level.
module gpio_in_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic update
);

  logic meta_r;
  logic sync_r;
  logic stable_r;
  logic update_s;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= pin;
      sync_r <= meta_r;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Accept the new level only after it has disagreed with stable for DEB_CYCLES samples
  always_comb begin
    if ((sync_r != stable_r) && (cnt_r == CNT_MAX)) begin
      update_s = 1'b1;
    end else begin
      update_s = 1'b0;
    end
  end

  // Mismatch counter; any agreement restarts the count so short glitches never complete it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if ((sync_r == stable_r) || update_s) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end
`else
  // Without debounce stable simply follows the synchroniser
  always_comb begin
    if (sync_r != stable_r) begin
      update_s = 1'b1;
    end else begin
      update_s = 1'b0;
    end
  end
`endif

  // Stable level flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_r <= 1'b0;
    end else if (update_s) begin
      stable_r <= sync_r;
    end else begin
      stable_r <= stable_r;
    end
  end

  assign stable = stable_r;
  assign update = update_s;

endmodule

// File: rtl/gpio_in_6502.sv
// GPIO input block on the 6502 bus: per-bit sync/debounce, W1C edge flags, mask/polarity and level IRQ.
// Debounce is enabled by defining GPIO_IN_DEBOUNCE_EN.
module gpio_in_6502
  import gpio_in_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_i,
  gpio_in_6502_if.slave    bus
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] update_s;
  logic [WIDTH-1:0] event_s;
  logic [WIDTH-1:0] edge_clr_s;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] pol_r;
  logic [7:0]       rd_data_s;
  logic [7:0]       dout_r;
  logic             irq_r;
  logic             wr_s;
  logic             rd_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_bit (
      .clk    (clk),
      .reset  (reset),
      .pin    (gpio_i[i]),
      .stable (stable_s[i]),
      .update (update_s[i])
    );
  end

  assign wr_s = bus.cs & bus.we;
  assign rd_s = bus.cs & ~bus.we;

  // An update is an event when the level being left is the one opposite the selected edge
  assign event_s = update_s & ~(stable_s ^ pol_r);

  // W1C clear mask for the EDGE register
  always_comb begin
    if (wr_s && (bus.addr == REG_EDGE)) begin
      edge_clr_s = bus.din[WIDTH-1:0];
    end else begin
      edge_clr_s = {WIDTH{1'b0}};
    end
  end

  // Edge flags: set has priority over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_r <= {WIDTH{1'b0}};
    end else begin
      edge_r <= (edge_r & ~edge_clr_s) | event_s;
    end
  end

  // MASK and POL write registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r <= {WIDTH{1'b0}};
      pol_r  <= {WIDTH{1'b0}};
    end else if (wr_s) begin
      case (bus.addr)
        REG_MASK: mask_r <= bus.din[WIDTH-1:0];
        REG_POL:  pol_r  <= bus.din[WIDTH-1:0];
        default: begin
          mask_r <= mask_r;
          pol_r  <= pol_r;
        end
      endcase
    end else begin
      mask_r <= mask_r;
      pol_r  <= pol_r;
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rd_data_s = 8'h00;
    case (bus.addr)
      REG_DATA: rd_data_s[WIDTH-1:0] = stable_s;
      REG_EDGE: rd_data_s[WIDTH-1:0] = edge_r;
      REG_MASK: rd_data_s[WIDTH-1:0] = mask_r;
      REG_POL:  rd_data_s[WIDTH-1:0] = pol_r;
      default:  rd_data_s = 8'h00;
    endcase
  end

  // Registered read data (held between reads) and level IRQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_r <= 8'h00;
      irq_r  <= 1'b0;
    end else begin
      if (rd_s) begin
        dout_r <= rd_data_s;
      end else begin
        dout_r <= dout_r;
      end
      irq_r <= |(edge_r & mask_r);
    end
  end

  assign bus.dout = dout_r;
  assign bus.irq  = irq_r;

endmodule

// File: tb/tb_gpio_in_6502.sv
// Scoreboard bench for gpio_in_6502: reads push expected dout/irq, a monitor pops and compares.
module tb_gpio_in_6502;
  import gpio_in_pkg::*;

  localparam int DEB = 16;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = LAT + 4;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic       irq;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] gpio;
  exp_t       sb[$];
  int         tests;
  int         fails;

  gpio_in_6502_if bus ();

  gpio_in_6502 #(.WIDTH(8), .DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .reset  (reset),
    .gpio_i (gpio),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read accepted at a posedge yields dout/irq just after that edge
  initial begin
    logic rd;
    exp_t e;
    forever begin
      @(posedge clk);
      rd = bus.cs & ~bus.we;
      #1;
      if (rd) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got read with %h expected no read", bus.dout);
        end else begin
          e = sb.pop_front();
          check({e.name, "_dout"}, bus.dout, e.dout);
          check({e.name, "_irq"}, {7'd0, bus.irq}, {7'd0, e.irq});
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] d, input logic q);
    exp_t e;
    @(negedge clk);
    e.name = name; e.dout = d; e.irq = q;
    sb.push_back(e);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    int n;
    tests = 0; fails = 0;
    gpio = 8'h00;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.din = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // T1: activity then mid-operation reset
    wr(REG_MASK, 8'hFF);
    gpio[1] = 1'b1;
    settle();
    rd("t1_edge_pre", REG_EDGE, 8'h02, 1'b1);
    gpio[1] = 1'b0;
    settle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1_dout_rst", bus.dout, 8'h00);
    check("t1_irq_rst", {7'd0, bus.irq}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    rd("t1_mask", REG_MASK, 8'h00, 1'b0);
    rd("t1_pol", REG_POL, 8'h00, 1'b0);
    rd("t1_edge", REG_EDGE, 8'h00, 1'b0);

    // T2: rising edge on bit 0 and irq latency
    wr(REG_MASK, 8'h01);
    wr(REG_POL, 8'h00);
    @(negedge clk);
    gpio[0] = 1'b1;
    n = 0;
    while (n < LAT + 10) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.irq) break;
    end
    tests++;
    if (!(bus.irq && n >= LAT + 1 && n <= LAT + 2)) begin
      fails++;
      $display("FAIL t2_irq_latency: got irq=%0b after %0d cycles expected irq=1 after %0d..%0d",
               bus.irq, n, LAT + 1, LAT + 2);
    end
    rd("t2_edge", REG_EDGE, 8'h01, 1'b1);
    rd("t2_data", REG_DATA, 8'h01, 1'b1);

    // T3: falling edge on bit 7, W1C clear
    wr(REG_POL, 8'h80);
    wr(REG_MASK, 8'h80);
    gpio[7] = 1'b1;
    settle();
    wr(REG_EDGE, 8'hFF);
    rd("t3_edge_rise_ignored", REG_EDGE, 8'h00, 1'b0);
    gpio[7] = 1'b0;
    settle();
    rd("t3_edge_fall", REG_EDGE, 8'h80, 1'b1);
    wr(REG_EDGE, 8'h80);
    check("t3_irq_after_w1c_edge", {7'd0, bus.irq}, 8'h01);
    rd("t3_edge_cleared", REG_EDGE, 8'h00, 1'b0);

`ifdef GPIO_IN_DEBOUNCE_EN
    // T4: glitch shorter than the debounce window is rejected
    wr(REG_MASK, 8'h08);
    wr(REG_POL, 8'h00);
    @(negedge clk);
    gpio[3] = 1'b1;
    repeat (DEB - 2) @(negedge clk);
    gpio[3] = 1'b0;
    settle();
    rd("t4_data", REG_DATA, 8'h01, 1'b0);
    rd("t4_edge", REG_EDGE, 8'h00, 1'b0);
`endif

    // T5: set wins over same-cycle W1C
    wr(REG_POL, 8'h00);
    wr(REG_MASK, 8'h04);
    gpio[2] = 1'b1;
    settle();
    gpio[2] = 1'b0;
    settle();
    rd("t5_edge_set", REG_EDGE, 8'h04, 1'b1);
    wr(REG_EDGE, 8'h00);
    rd("t5_w1c_zero", REG_EDGE, 8'h04, 1'b1);
    gpio[2] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = REG_EDGE; bus.din = 8'h04;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
    check("t5_irq_collision", {7'd0, bus.irq}, 8'h01);
    rd("t5_edge_collision", REG_EDGE, 8'h04, 1'b1);
    rd("t5_data", REG_DATA, 8'h05, 1'b1);

    // T6: read timing, dout hold, DATA write ignored, POL change is not an event
    gpio = 8'hA5;
    settle();
    rd("t6_data", REG_DATA, 8'hA5, 1'b1);
    @(negedge clk);
    check("t6_dout_hold", bus.dout, 8'hA5);
    wr(REG_DATA, 8'h00);
    rd("t6_data_after_wr", REG_DATA, 8'hA5, 1'b1);
    rd("t6_edge", REG_EDGE, 8'hA4, 1'b1);
    rd("t6_mask", REG_MASK, 8'h04, 1'b1);
    rd("t6_pol", REG_POL, 8'h00, 1'b1);
    wr(REG_EDGE, 8'hFF);
    wr(REG_POL, 8'hFF);
    repeat (4) @(negedge clk);
    rd("t6_pol_change", REG_EDGE, 8'h00, 1'b0);
    rd("t6_pol_rb", REG_POL, 8'hFF, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
